// File: rtl/ttt_move_if.sv
// Requester/arbiter bus plus human-move handshake for the tic-tac-toe requester.
// master = requester (drives req), slave = arbiter/human side (drives gnt and moves).
interface ttt_move_if;
  logic       human_valid;
  logic [3:0] human_pos;
  logic       human_ready;
  logic       illegal;
  logic [8:0] req;
  logic [8:0] gnt;

  modport master (input  human_valid, human_pos, gnt,
                  output human_ready, illegal, req);
  modport slave  (output human_valid, human_pos, gnt,
                  input  human_ready, illegal, req);
endinterface

// File: rtl/ttt_move_requester.sv
// Tic-tac-toe board owner: takes human moves, walks computer tiers (win, block,
// center, corner, any) through an external MSB-priority arbiter, and detects win/draw.
module ttt_move_requester #(
  parameter bit HUMAN_FIRST = 1'b1,
  parameter int CENTER_IDX  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  ttt_move_if.master       mif,
  output logic [8:0]       x_board,
  output logic [8:0]       o_board,
  output logic [3:0]       move_count,
  output logic [1:0]       winner,
  output logic             game_over
);
  typedef enum logic [3:0] {
    S_HUMAN, S_EVAL_X, S_WIN, S_BLOCK, S_CENTER, S_CORNER, S_ANY, S_EVAL_O, S_OVER
  } state_t;

  localparam state_t     S_START     = HUMAN_FIRST ? S_HUMAN : S_WIN;
  localparam logic [8:0] CENTER_MASK = 9'(1) << CENTER_IDX;
  localparam logic [8:0] CORNER_MASK = 9'h145;
  // rows, cols, diagonals; bit i = cell i
  localparam logic [7:0][8:0] LINES = {9'h054, 9'h111, 9'h124, 9'h092,
                                       9'h049, 9'h1C0, 9'h038, 9'h007};

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d, o_q, o_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] win_q, win_d;
  logic       illegal_q, illegal_d;
  logic [8:0] empty, req_w, g, pos_mask;
  logic       g_ok;

  function automatic logic has_line(input logic [8:0] b);
    has_line = 1'b0;
    for (int i = 0; i < 8; i++) if ((b & LINES[i]) == LINES[i]) has_line = 1'b1;
  endfunction

  // empty cells that would complete a line already holding two of b
  function automatic logic [8:0] two_of(input logic [8:0] b, input logic [8:0] e);
    two_of = '0;
    for (int i = 0; i < 8; i++)
      if ($countones(b & LINES[i]) == 2) two_of = two_of | (LINES[i] & e);
  endfunction

  assign empty = ~(x_q | o_q);

  always_comb begin
    req_w = '0;
    case (state_q)
      S_WIN:    req_w = two_of(o_q, empty);
      S_BLOCK:  req_w = two_of(x_q, empty);
      S_CENTER: req_w = CENTER_MASK & empty;
      S_CORNER: req_w = CORNER_MASK & empty;
      S_ANY:    req_w = empty;
      default:  req_w = '0;
    endcase
  end

  // out-of-request grant bits are dropped; a multi-hot remainder is treated as no grant
  assign g        = mif.gnt & req_w;
  assign g_ok     = (g != '0) && ((g & (g - 9'd1)) == '0);
  assign pos_mask = 9'(1) << mif.human_pos;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    o_d       = o_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    illegal_d = 1'b0;
    case (state_q)
      S_HUMAN: if (mif.human_valid) begin
        if (mif.human_pos <= 4'd8 && (pos_mask & empty) != '0) begin
          x_d     = x_q | pos_mask;
          cnt_d   = cnt_q + 4'd1;
          state_d = S_EVAL_X;
        end else begin
          illegal_d = 1'b1;
        end
      end
      S_EVAL_X: begin
        if (has_line(x_q))        begin win_d = 2'b01; state_d = S_OVER; end
        else if (cnt_q == 4'd9)   begin win_d = 2'b11; state_d = S_OVER; end
        else                      state_d = S_WIN;
      end
      S_WIN, S_BLOCK, S_CENTER, S_CORNER, S_ANY: begin
        if (g_ok) begin
          o_d     = o_q | g;
          cnt_d   = cnt_q + 4'd1;
          state_d = S_EVAL_O;
        end else begin
          case (state_q)
            S_WIN:    state_d = S_BLOCK;
            S_BLOCK:  state_d = S_CENTER;
            S_CENTER: state_d = S_CORNER;
            S_CORNER: state_d = S_ANY;
            default:  begin win_d = 2'b11; state_d = S_OVER; end
          endcase
        end
      end
      S_EVAL_O: begin
        if (has_line(o_q))        begin win_d = 2'b10; state_d = S_OVER; end
        else if (cnt_q == 4'd9)   begin win_d = 2'b11; state_d = S_OVER; end
        else                      state_d = S_HUMAN;
      end
      default: state_d = state_q;
    endcase
    if (new_game) begin
      state_d   = S_START;
      x_d       = '0;
      o_d       = '0;
      cnt_d     = '0;
      win_d     = '0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_START;
      x_q       <= '0;
      o_q       <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      o_q       <= o_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      illegal_q <= illegal_d;
    end
  end

  assign mif.req         = req_w;
  assign mif.human_ready = (state_q == S_HUMAN);
  assign mif.illegal     = illegal_q;
  assign x_board         = x_q;
  assign o_board         = o_q;
  assign move_count      = cnt_q;
  assign winner          = win_q;
  assign game_over       = (state_q == S_OVER);
endmodule

// File: tb/tb_ttt_move_requester.sv
// Directed bench: per-cycle vector table on a human-first instance, plus hand
// sequences on a computer-first instance (center tier, new_game mid-tier, grant errors).
module tb_ttt_move_requester;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int bad = 0;

  ttt_move_if aif ();
  ttt_move_if bif ();

  logic       rst_a, ng_a, rst_b, ng_b;
  logic [8:0] xa, oa, xb, ob;
  logic [3:0] ca, cb;
  logic [1:0] wa, wb;
  logic       ova, ovb;
  logic       frc_en;
  logic [8:0] frc_gnt;

  // reference MSB-priority arbiter
  function automatic logic [8:0] msb1h(input logic [8:0] r);
    msb1h = '0;
    for (int i = 0; i < 9; i++) if (r[i]) msb1h = 9'(1) << i;
  endfunction

  assign aif.gnt = msb1h(aif.req);
  assign bif.gnt = frc_en ? frc_gnt : msb1h(bif.req);

  ttt_move_requester #(.HUMAN_FIRST(1'b1), .CENTER_IDX(4)) dut_a (
    .clk(clk), .reset(rst_a), .new_game(ng_a), .mif(aif),
    .x_board(xa), .o_board(oa), .move_count(ca), .winner(wa), .game_over(ova));

  ttt_move_requester #(.HUMAN_FIRST(1'b0), .CENTER_IDX(4)) dut_b (
    .clk(clk), .reset(rst_b), .new_game(ng_b), .mif(bif),
    .x_board(xb), .o_board(ob), .move_count(cb), .winner(wb), .game_over(ovb));

  typedef struct {
    logic       rst, ng, hv;
    logic [3:0] pos;
    logic [8:0] req, x, o;
    logic [3:0] cnt;
    logic [1:0] win;
    logic       rdy, ill, ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ng, hv, input logic [3:0] pos,
                              input logic [8:0] req, x, o, input logic [3:0] cnt,
                              input logic [1:0] win, input logic rdy, ill, ovr);
    vec_t v;
    v.rst = rst; v.ng = ng; v.hv = hv; v.pos = pos;
    v.req = req; v.x = x; v.o = o; v.cnt = cnt; v.win = win;
    v.rdy = rdy; v.ill = ill; v.ovr = ovr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; ng_a = 1'b0; rst_b = 1'b1; ng_b = 1'b0;
    aif.human_valid = 1'b0; aif.human_pos = '0;
    bif.human_valid = 1'b0; bif.human_pos = '0;
    frc_en = 1'b0; frc_gnt = '0;

    //                 rst ng hv pos   req     x       o     cnt  win rdy ill ovr
    vecs.push_back(mk(1, 0, 0, 0, 9'h000, 9'h000, 9'h000, 0, 0, 1, 0, 0)); // reset
    vecs.push_back(mk(0, 0, 1, 4, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0)); // EVAL_X
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0)); // WIN
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0)); // BLOCK
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0)); // CENTER
    vecs.push_back(mk(0, 0, 0, 0, 9'h145, 9'h010, 9'h000, 1, 0, 0, 0, 0)); // CORNER
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h100, 2, 0, 0, 0, 0)); // EVAL_O
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h100, 2, 0, 1, 0, 0)); // HUMAN
    vecs.push_back(mk(0, 0, 1, 2, 9'h000, 9'h014, 9'h100, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h014, 9'h100, 3, 0, 0, 0, 0)); // WIN
    vecs.push_back(mk(0, 0, 0, 0, 9'h040, 9'h014, 9'h100, 3, 0, 0, 0, 0)); // BLOCK
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h014, 9'h140, 4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h014, 9'h140, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4, 9'h000, 9'h014, 9'h140, 4, 0, 1, 1, 0)); // occupied
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h014, 9'h140, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 9, 9'h000, 9'h014, 9'h140, 4, 0, 1, 1, 0)); // pos 9
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h014, 9'h140, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 9'h000, 9'h000, 9'h000, 0, 0, 1, 0, 0)); // new_game
    vecs.push_back(mk(0, 0, 1, 4, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h145, 9'h010, 9'h000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h100, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h010, 9'h100, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 9'h000, 9'h011, 9'h100, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h011, 9'h100, 3, 0, 0, 0, 0)); // WIN
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h011, 9'h100, 3, 0, 0, 0, 0)); // BLOCK (8 taken)
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h011, 9'h100, 3, 0, 0, 0, 0)); // CENTER
    vecs.push_back(mk(0, 0, 0, 0, 9'h044, 9'h011, 9'h100, 3, 0, 0, 0, 0)); // CORNER
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h011, 9'h140, 4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h011, 9'h140, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 9'h000, 9'h019, 9'h140, 5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h080, 9'h019, 9'h140, 5, 0, 0, 0, 0)); // WIN
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h019, 9'h1C0, 6, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h019, 9'h1C0, 6, 2, 0, 0, 1)); // OVER
    vecs.push_back(mk(0, 0, 1, 5, 9'h000, 9'h019, 9'h1C0, 6, 2, 0, 0, 1)); // ignored
    vecs.push_back(mk(0, 0, 1, 5, 9'h000, 9'h019, 9'h1C0, 6, 2, 0, 0, 1));

    foreach (vecs[i]) begin
      rst_a = vecs[i].rst; ng_a = vecs[i].ng;
      aif.human_valid = vecs[i].hv; aif.human_pos = vecs[i].pos;
      step();
      chk("req",   i, 16'(aif.req),         16'(vecs[i].req));
      chk("x",     i, 16'(xa),              16'(vecs[i].x));
      chk("o",     i, 16'(oa),              16'(vecs[i].o));
      chk("cnt",   i, 16'(ca),              16'(vecs[i].cnt));
      chk("win",   i, 16'(wa),              16'(vecs[i].win));
      chk("rdy",   i, 16'(aif.human_ready), 16'(vecs[i].rdy));
      chk("ill",   i, 16'(aif.illegal),     16'(vecs[i].ill));
      chk("over",  i, 16'(ova),             16'(vecs[i].ovr));
    end

    // computer-first: reset, then tiers run WIN, BLOCK, CENTER
    rst_b = 1'b1; step(); rst_b = 1'b0;
    chk("b_rst_req", 100, 16'(bif.req), 16'h000);
    chk("b_rst_o",   100, 16'(ob),      16'h000);
    chk("b_rst_rdy", 100, 16'(bif.human_ready), 16'h0);
    step(); chk("b_block_req",  101, 16'(bif.req), 16'h000);
    step(); chk("b_center_req", 102, 16'(bif.req), 16'h010);
    step(); chk("b_o",          103, 16'(ob),      16'h010);
    chk("b_cnt", 103, 16'(cb), 16'h1);
    step(); chk("b_rdy",        104, 16'(bif.human_ready), 16'h1);

    // human 0, then new_game while in CORNER
    bif.human_valid = 1'b1; bif.human_pos = 4'd0; step(); bif.human_valid = 1'b0;
    chk("b_x", 105, 16'(xb), 16'h001);
    step(); step(); step(); step();
    chk("b_corner_req", 106, 16'(bif.req), 16'h144);
    ng_b = 1'b1; step(); ng_b = 1'b0;
    chk("b_ng_x",   107, 16'(xb),      16'h000);
    chk("b_ng_o",   107, 16'(ob),      16'h000);
    chk("b_ng_cnt", 107, 16'(cb),      16'h0);
    chk("b_ng_req", 107, 16'(bif.req), 16'h000);

    // stray grant bits outside req are masked: all-ones grant commits center only
    frc_en = 1'b1; frc_gnt = 9'h1FF;
    step(); step();
    chk("b_center_req2", 108, 16'(bif.req), 16'h010);
    step(); chk("b_mask_o", 109, 16'(ob), 16'h010);
    step();
    bif.human_valid = 1'b1; bif.human_pos = 4'd0; step(); bif.human_valid = 1'b0;
    step(); step(); step(); step();
    chk("b_corner_req2", 110, 16'(bif.req), 16'h144);
    // multi-hot grant is not committed; falls through to ANY
    step();
    chk("b_multi_o",   111, 16'(ob),      16'h010);
    chk("b_any_req",   111, 16'(bif.req), 16'h1EE);
    frc_en = 1'b0;
    step();
    chk("b_any_o",   112, 16'(ob), 16'h110);
    chk("b_any_cnt", 112, 16'(cb), 16'h3);
    step();
    chk("b_back_rdy", 113, 16'(bif.human_ready), 16'h1);
    chk("b_back_win", 113, 16'(wb), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
